// File: rtl/lfsr_multi_pipe.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_multi_pipe
// Brief    : NCH Fibonacci LFSRs on one shared input bit stream; the XOR of the
//            bits shifted out of all channels is queued in a DEPTH-entry FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module lfsr_multi_pipe #(
    parameter int             LN    = 8,
    parameter logic [LN-1:0]  TAPS  = LN'(45),
    parameter int             NCH   = 2,
    parameter logic [LN-1:0]  INIT  = LN'(1),
    parameter int             DEPTH = 4,
    parameter int             CNTW  = 16,
    localparam int            SW    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                shiftBit__ENA,
    input  logic                shiftBit_v,
    output logic                shiftBit__RDY,
    input  logic                seed__ENA,
    input  logic [SW-1:0]       seed_ch,
    input  logic [LN-1:0]       seed_v,
    output logic                seed__RDY,
    output logic                outBit,
    output logic                outBit__RDY,
    input  logic                outDeq__ENA,
    output logic                outDeq__RDY,
    output logic [CNTW-1:0]     shiftCount,
    output logic [NCH*LN-1:0]   chState
);

    localparam int             AW      = $clog2(DEPTH);
    localparam logic [AW:0]    C_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW:0]    C_ONE   = (AW+1)'(1);

    logic [NCH-1:0]   w_msb;
    logic             w_push;
    logic             w_pop;
    logic             w_comb;
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_occ;
    logic [AW:0]      w_occ_nxt;
    logic             r_not_full;
    logic             r_not_empty;
    logic [DEPTH-1:0] r_mem;
    logic [CNTW-1:0]  r_cnt;

    assign w_push = shiftBit__ENA & r_not_full;
    assign w_pop  = outDeq__ENA & r_not_empty;

    generate
        for (genvar c = 0; c < NCH; c++) begin : g_ch
            logic [LN-1:0] r_s;
            logic          w_fb;
            logic          w_seed_hit;

            assign w_fb       = (^(r_s & TAPS)) ^ shiftBit_v;
            assign w_seed_hit = seed__ENA && (seed_ch == SW'(c));
            assign w_msb[c]   = r_s[LN-1];
            assign chState[c*LN +: LN] = r_s;

            // A seed overrides a same-cycle shift; the shifted-out bit still
            // comes from the pre-seed state through w_msb.
            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    r_s <= INIT;
                end else if (w_seed_hit) begin
                    r_s <= seed_v;
                end else if (w_push) begin
                    r_s <= {r_s[LN-2:0], w_fb};
                end
            end
        end
    endgenerate

    assign w_comb = ^w_msb;

    always_comb begin
        w_occ_nxt = r_occ;
        case ({w_push, w_pop})
            2'b10:   w_occ_nxt = r_occ + C_ONE;
            2'b01:   w_occ_nxt = r_occ - C_ONE;
            default: w_occ_nxt = r_occ;
        endcase
    end

    // Ready flags are registered from the next occupancy so they never see ENA
    // combinationally.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_wr        <= '0;
            r_rd        <= '0;
            r_occ       <= '0;
            r_not_full  <= 1'b1;
            r_not_empty <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_occ       <= w_occ_nxt;
            r_not_full  <= (w_occ_nxt != C_FULL);
            r_not_empty <= (w_occ_nxt != '0);
            if (w_push) begin
                r_wr  <= r_wr + 1'b1;
                r_cnt <= r_cnt + CNTW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr] <= w_comb;
        end
    end

    assign outBit        = r_not_empty & r_mem[r_rd];
    assign outBit__RDY   = r_not_empty;
    assign outDeq__RDY   = r_not_empty;
    assign shiftBit__RDY = r_not_full;
    assign seed__RDY     = 1'b1;
    assign shiftCount    = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_multi_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_lfsr_multi_pipe
// Brief    : Directed and random checks of lfsr_multi_pipe against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lfsr_multi_pipe;

    localparam int          LN    = 8;
    localparam int          NCH   = 2;
    localparam int          DEPTH = 4;
    localparam logic [7:0]  TAPS  = 8'h2D;

    logic        clk = 1'b0;
    logic        nrst;
    logic        sh_ena, sh_v, seed_ena, deq;
    logic [0:0]  seed_ch;
    logic [7:0]  seed_v;
    logic        sh_rdy, seed_rdy, ob, ob_rdy, deq_rdy;
    logic [15:0] cnt;
    logic [15:0] st;
    logic        sh_rdy4, seed_rdy4, ob4, ob_rdy4, deq_rdy4;
    logic [3:0]  cnt4;
    logic [15:0] st4;

    logic [7:0]  ms [NCH];
    bit          mq [$];
    int unsigned mcnt;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    lfsr_multi_pipe #(.LN(LN), .TAPS(TAPS), .NCH(NCH), .INIT(8'h01), .DEPTH(DEPTH), .CNTW(16)) u_dut (
        .CLK(clk), .nRST(nrst),
        .shiftBit__ENA(sh_ena), .shiftBit_v(sh_v), .shiftBit__RDY(sh_rdy),
        .seed__ENA(seed_ena), .seed_ch(seed_ch), .seed_v(seed_v), .seed__RDY(seed_rdy),
        .outBit(ob), .outBit__RDY(ob_rdy), .outDeq__ENA(deq), .outDeq__RDY(deq_rdy),
        .shiftCount(cnt), .chState(st)
    );

    lfsr_multi_pipe #(.LN(LN), .TAPS(TAPS), .NCH(NCH), .INIT(8'h01), .DEPTH(DEPTH), .CNTW(4)) u_dut4 (
        .CLK(clk), .nRST(nrst),
        .shiftBit__ENA(sh_ena), .shiftBit_v(sh_v), .shiftBit__RDY(sh_rdy4),
        .seed__ENA(seed_ena), .seed_ch(seed_ch), .seed_v(seed_v), .seed__RDY(seed_rdy4),
        .outBit(ob4), .outBit__RDY(ob_rdy4), .outDeq__ENA(deq), .outDeq__RDY(deq_rdy4),
        .shiftCount(cnt4), .chState(st4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] s, input logic v);
        int fb;
        fb = ($countones(s & TAPS) % 2) ^ int'(v);
        return 8'(((int'(s) * 2) + fb) % 256);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) ms[c] = 8'h01;
        mq.delete();
        mcnt = 0;
    endtask

    task automatic check_all(input string tag);
        int sz;
        sz = mq.size();
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("%s_ch%0d", tag, c), 32'(st[c*8 +: 8]), 32'(ms[c]));
            chk($sformatf("%s_ch%0d_w4", tag, c), 32'(st4[c*8 +: 8]), 32'(ms[c]));
        end
        chk({tag, "_cnt"}, 32'(cnt), mcnt % 65536);
        chk({tag, "_cnt4"}, 32'(cnt4), mcnt % 16);
        chk({tag, "_outrdy"}, 32'(ob_rdy), 32'(sz != 0));
        chk({tag, "_deqrdy"}, 32'(deq_rdy), 32'(sz != 0));
        chk({tag, "_shrdy"}, 32'(sh_rdy), 32'(sz < DEPTH));
        chk({tag, "_outbit"}, 32'(ob), (sz != 0) ? 32'(mq[0]) : 32'd0);
        chk({tag, "_seedrdy"}, 32'(seed_rdy), 32'd1);
    endtask

    // Drives one cycle from a negedge, advances the model at the posedge and
    // returns at the following negedge with inputs idle.
    task automatic cycle(input logic s, input logic v, input logic sd, input logic sch,
                         input logic [7:0] sv, input logic p);
        bit o;
        if ((s && mq.size() >= DEPTH) || (p && mq.size() == 0)) begin
            n_fail++;
            $error("FAIL protocol observed=shift%0b_pop%0b expected=legal_at_occ%0d", s, p, mq.size());
        end
        sh_ena = s; sh_v = v; seed_ena = sd; seed_ch = sch; seed_v = sv; deq = p;
        @(posedge clk);
        o = 1'b0;
        for (int c = 0; c < NCH; c++) o ^= ms[c][7];
        for (int c = 0; c < NCH; c++) begin
            if (sd && int'(sch) == c) ms[c] = sv;
            else if (s)               ms[c] = lfsr_next(ms[c], v);
        end
        if (p) void'(mq.pop_front());
        if (s) begin
            mq.push_back(o);
            mcnt++;
        end
        @(negedge clk);
        sh_ena = 0; sh_v = 0; seed_ena = 0; seed_ch = 0; seed_v = 0; deq = 0;
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        nrst = 1'b1;
    endtask

    initial begin
        sh_ena = 0; sh_v = 0; seed_ena = 0; seed_ch = 0; seed_v = 0; deq = 0;
        nrst = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        chk("reset_state", 32'(st), 32'h0101);
        nrst = 1'b1;
        @(negedge clk);

        // basic shift
        cycle(1, 0, 0, 0, 8'h00, 0);
        chk("basic_st1", 32'(st), 32'h0303);
        cycle(1, 0, 0, 0, 8'h00, 0);
        chk("basic_st2", 32'(st), 32'h0707);
        chk("basic_cnt", 32'(cnt), 32'd2);
        check_all("basic");
        chk("basic_head0", 32'(ob), 32'd0);
        cycle(0, 0, 0, 0, 8'h00, 1);
        chk("basic_head1", 32'(ob), 32'd0);
        check_all("basic_pop");

        // seed then combine
        do_reset();
        cycle(0, 0, 1, 1, 8'h80, 0);
        check_all("seed");
        cycle(1, 0, 0, 0, 8'h00, 0);
        chk("seed_st", 32'(st), 32'h0003);
        chk("seed_bit", 32'(ob), 32'd1);
        check_all("seed_shift");
        cycle(0, 0, 0, 0, 8'h00, 1);

        // seed/shift collision
        do_reset();
        cycle(1, 1, 1, 0, 8'hAA, 0);
        chk("coll_st", 32'(st), 32'h02AA);
        chk("coll_bit", 32'(ob), 32'd0);
        chk("coll_rdy", 32'(ob_rdy), 32'd1);
        check_all("coll");

        // full and empty
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1, 1'($urandom), 0, 0, 8'h00, 0);
            check_all("fill");
        end
        chk("full_shrdy", 32'(sh_rdy), 32'd0);
        cycle(0, 0, 0, 0, 8'h00, 1);
        chk("pop_shrdy", 32'(sh_rdy), 32'd1);
        for (int i = 0; i < DEPTH - 1; i++) begin
            cycle(0, 0, 0, 0, 8'h00, 1);
            check_all("drain");
        end
        chk("empty_rdy", 32'(ob_rdy), 32'd0);
        chk("empty_bit", 32'(ob), 32'd0);

        // simultaneous push/pop at occupancy 2, then random traffic
        do_reset();
        cycle(1, 1'($urandom), 0, 0, 8'h00, 0);
        cycle(1, 1'($urandom), 0, 0, 8'h00, 0);
        for (int i = 0; i < 8; i++) begin
            cycle(1, 1'($urandom), 0, 0, 8'h00, 1);
            chk("pp_occ", 32'(mq.size()), 32'd2);
            check_all("pushpop");
        end
        for (int i = 0; i < 1000; i++) begin
            logic s, p;
            s = (mq.size() < DEPTH) && ($urandom % 4 != 0);
            p = (mq.size() > 0) && ($urandom % 3 != 0);
            cycle(s, 1'($urandom), ($urandom % 8 == 0), 1'($urandom), 8'($urandom), p);
            check_all("rand");
        end

        // asynchronous reset mid-operation
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1, 1'($urandom), 0, 0, 8'h00, 0);
        check_all("pre_rst");
        #2;
        nrst = 1'b0;
        #1;
        chk("arst_outrdy", 32'(ob_rdy), 32'd0);
        chk("arst_cnt", 32'(cnt), 32'd0);
        chk("arst_st", 32'(st), 32'h0101);
        chk("arst_shrdy", 32'(sh_rdy), 32'd1);
        chk("arst_bit", 32'(ob), 32'd0);
        model_reset();
        @(negedge clk);
        nrst = 1'b1;
        check_all("post_rst");

        // counter wrap on the CNTW=4 instance
        for (int i = 0; i < 17; i++) cycle(1, 1'($urandom), 0, 0, 8'h00, (mq.size() > 0));
        chk("wrap_cnt4", 32'(cnt4), 32'd1);
        chk("wrap_cnt16", 32'(cnt), 32'd17);
        check_all("wrap");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
